// File: rtl/pcileech_sysctl.sv
// System-control block for PCILeech board tops: button synchronise/debounce,
// short/long press detection, stretched system reset, cfg-reload request,
// free-running 64-bit tickcount and a power-on blink overlay on the LEDs.
module pcileech_sysctl #(
  parameter int unsigned          NUM_BTN      = 2,
  parameter int unsigned          NUM_LED      = 2,
  parameter int unsigned          RST_BTN      = 1,
  parameter int unsigned          DEBOUNCE_CYC = 1000000,
  parameter int unsigned          LONG_CYC     = 500000000,
  parameter int unsigned          RST_STRETCH  = 64,
  parameter int unsigned          BLINK_BIT    = 24,
  parameter int unsigned          PWRON_BITS   = 27,
  parameter logic [NUM_LED-1:0]   BLINK_MASK   = '1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_BTN-1:0] btn_n_i,
  input  logic [NUM_LED-1:0] led_src_i,
  output logic [NUM_LED-1:0] led_out_o,
  output logic [NUM_BTN-1:0] btn_held_o,
  output logic [NUM_BTN-1:0] btn_short_o,
  output logic [NUM_BTN-1:0] btn_long_o,
  output logic               sys_rst_o,
  output logic               cfg_reload_o,
  output logic [63:0]        tickcount_o
);

  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYC);
  localparam int unsigned HoldW = $clog2(LONG_CYC + 1);
  localparam int unsigned StW   = $clog2(RST_STRETCH + 1);

  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYC - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYC - 1);
  localparam logic [StW-1:0]   StLoad   = StW'(RST_STRETCH);

  typedef enum logic [1:0] {StIdle, StPress, StLong} press_st_e;

  logic [NUM_BTN-1:0]           sync1_q, sync2_q;
  logic [NUM_BTN-1:0]           pressed;
  logic [NUM_BTN-1:0]           held_q, held_d;
  logic [NUM_BTN-1:0][DbW-1:0]  db_cnt_q, db_cnt_d;
  press_st_e                    st_q [NUM_BTN];
  press_st_e                    st_d [NUM_BTN];
  logic [NUM_BTN-1:0][HoldW-1:0] hold_q, hold_d;
  logic [NUM_BTN-1:0]           short_q, short_d;
  logic [NUM_BTN-1:0]           long_q, long_d;
  logic [StW-1:0]               st_cnt_q, st_cnt_d;
  logic                         sys_rst_q, sys_rst_d;
  logic [63:0]                  tick_q, tick_d;
  logic [NUM_LED-1:0]           led_q, led_d;
  logic                         blink;

  // Two-flop synchroniser; resets to the released (high) pad level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = ~sync2_q;

  // Debounce: accept a new level only after DEBOUNCE_CYC consecutive differing samples.
  always_comb begin
    held_d   = held_q;
    db_cnt_d = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (pressed[i] != held_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          held_d[i] = pressed[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  // Debounced level and its stability counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      held_q   <= '0;
      db_cnt_q <= '0;
    end else begin
      held_q   <= held_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Press FSM state register; it follows the debounced level on the edge it changes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        st_q[i] <= StIdle;
      end
      hold_q <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        st_q[i] <= st_d[i];
      end
      hold_q <= hold_d;
    end
  end

  // Press FSM next state; a release in the same cycle as the long point wins.
  always_comb begin
    hold_d = hold_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      st_d[i] = st_q[i];
      case (st_q[i])
        StIdle: begin
          if (held_d[i]) begin
            st_d[i]   = StPress;
            hold_d[i] = '0;
          end
        end
        StPress: begin
          if (!held_d[i]) begin
            st_d[i] = StIdle;
          end else if (hold_q[i] == HoldLast) begin
            st_d[i] = StLong;
          end else begin
            hold_d[i] = hold_q[i] + HoldW'(1);
          end
        end
        StLong: begin
          if (!held_d[i]) begin
            st_d[i] = StIdle;
          end
        end
        default: st_d[i] = StIdle;
      endcase
    end
  end

  // Press FSM outputs: pulse requests derived from the PRESS exits, cfg reload level.
  always_comb begin
    short_d = '0;
    long_d  = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (st_q[i] == StPress) begin
        short_d[i] = !held_d[i];
        long_d[i]  = held_d[i] && (hold_q[i] == HoldLast);
      end
    end
    cfg_reload_o = (st_q[RST_BTN] == StLong);
  end

  // Registered one-cycle press pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      short_q <= '0;
      long_q  <= '0;
    end else begin
      short_q <= short_d;
      long_q  <= long_d;
    end
  end

  // Reset stretch, tickcount and LED overlay next state.
  always_comb begin
    if (held_q[RST_BTN]) begin
      st_cnt_d = StLoad;
      tick_d   = '0;
    end else begin
      st_cnt_d = (st_cnt_q != '0) ? st_cnt_q - StW'(1) : '0;
      tick_d   = tick_q + 64'd1;
    end
    sys_rst_d = (st_cnt_d != '0);
    blink     = tick_q[BLINK_BIT] && (tick_q[63:PWRON_BITS] == '0);
    led_d     = led_src_i ^ (BLINK_MASK & {NUM_LED{blink}});
  end

  // Reset stretch, tickcount and LED registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_cnt_q  <= StLoad;
      sys_rst_q <= 1'b1;
      tick_q    <= '0;
      led_q     <= '0;
    end else begin
      st_cnt_q  <= st_cnt_d;
      sys_rst_q <= sys_rst_d;
      tick_q    <= tick_d;
      led_q     <= led_d;
    end
  end

  assign btn_held_o  = held_q;
  assign btn_short_o = short_q;
  assign btn_long_o  = long_q;
  assign sys_rst_o   = sys_rst_q;
  assign tickcount_o = tick_q;
  assign led_out_o   = led_q;

endmodule

// File: tb/tb_pcileech_sysctl.sv
// Scoreboard bench for pcileech_sysctl. Stimulus pushes hand-computed expected
// output-change events and periodic samples; a monitor compares on each negedge.
module tb_pcileech_sysctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  btn_n = 2'b11;
  logic [1:0]  led_src = 2'b11;
  logic [1:0]  led_out, btn_held, btn_short, btn_long;
  logic        sys_rst, cfg_reload;
  logic [63:0] tickcount;

  pcileech_sysctl #(
    .NUM_BTN     (2),
    .NUM_LED     (2),
    .RST_BTN     (1),
    .DEBOUNCE_CYC(4),
    .LONG_CYC    (20),
    .RST_STRETCH (8),
    .BLINK_BIT   (2),
    .PWRON_BITS  (5),
    .BLINK_MASK  (2'b01)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .btn_n_i     (btn_n),
    .led_src_i   (led_src),
    .led_out_o   (led_out),
    .btn_held_o  (btn_held),
    .btn_short_o (btn_short),
    .btn_long_o  (btn_long),
    .sys_rst_o   (sys_rst),
    .cfg_reload_o(cfg_reload),
    .tickcount_o (tickcount)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // obs = {cfg_reload, sys_rst, btn_long[1:0], btn_short[1:0], btn_held[1:0]}
  typedef struct {int cyc; logic [7:0] obs;} ev_t;
  typedef struct {int cyc; logic [63:0] tick; logic [1:0] led; logic [7:0] obs;} smp_t;

  ev_t  ev_q[$];
  smp_t smp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic push_ev(input int c, input logic [7:0] o);
    ev_t e;
    e.cyc = c;
    e.obs = o;
    ev_q.push_back(e);
  endtask

  task automatic push_smp(input int c, input logic [63:0] t, input logic [1:0] l,
                          input logic [7:0] o);
    smp_t s;
    s.cyc  = c;
    s.tick = t;
    s.led  = l;
    s.obs  = o;
    smp_q.push_back(s);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
    #2;
  endtask

  // Monitor: every change of the observed outputs must match the next expected event.
  initial begin
    logic [7:0] prev, cur;
    prev = 8'h40;
    forever begin
      @(negedge clk);
      cur = {cfg_reload, sys_rst, btn_long, btn_short, btn_held};
      if (cur !== prev) begin
        n_chk++;
        if (ev_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change cyc=%0d got obs=%h, required obs=%h", cyc, cur, prev);
        end else begin
          ev_t e;
          e = ev_q.pop_front();
          if (e.cyc != cyc || e.obs !== cur) begin
            n_fail++;
            $display("FAIL event got cyc=%0d obs=%h, required cyc=%0d obs=%h",
                     cyc, cur, e.cyc, e.obs);
          end
        end
        prev = cur;
      end
      while (smp_q.size() != 0 && smp_q[0].cyc <= cyc) begin
        smp_t s;
        s = smp_q.pop_front();
        n_chk++;
        if (s.cyc != cyc || tickcount !== s.tick || led_out !== s.led || cur !== s.obs) begin
          n_fail++;
          $display("FAIL sample cyc=%0d got tick=%0d led=%b obs=%h, required cyc=%0d tick=%0d led=%b obs=%h",
                   cyc, tickcount, led_out, cur, s.cyc, s.tick, s.led, s.obs);
        end
      end
    end
  end

  initial begin
    // 1: reset stretch, tickcount from 0, blink window ends at tickcount 32
    push_smp(2, 64'd0, 2'b00, 8'h40);
    push_smp(5, 64'd2, 2'b01, 8'h40);
    push_smp(8, 64'd5, 2'b00, 8'h40);
    push_ev(11, 8'h00);
    push_smp(12, 64'd9, 2'b01, 8'h00);
    push_smp(35, 64'd32, 2'b00, 8'h00);
    push_smp(36, 64'd33, 2'b01, 8'h00);
    push_smp(40, 64'd37, 2'b01, 8'h00);
    wait_cyc(3);
    rst     = 1'b0;
    led_src = 2'b01;

    // 2: 3-cycle glitch on button 0, no events expected
    wait_cyc(50);
    btn_n[0] = 1'b0;
    wait_cyc(53);
    btn_n[0] = 1'b1;

    // 3: short press on button 0
    push_ev(76, 8'h01);
    push_ev(86, 8'h04);
    push_ev(87, 8'h00);
    wait_cyc(70);
    btn_n[0] = 1'b0;
    wait_cyc(80);
    btn_n[0] = 1'b1;

    // 4: long press on button 0
    push_ev(106, 8'h01);
    push_ev(126, 8'h11);
    push_ev(127, 8'h01);
    push_ev(146, 8'h00);
    wait_cyc(100);
    btn_n[0] = 1'b0;
    wait_cyc(140);
    btn_n[0] = 1'b1;

    // 5: long press on the reset button
    push_smp(150, 64'd147, 2'b01, 8'h00);
    push_ev(166, 8'h02);
    push_ev(167, 8'h42);
    push_smp(180, 64'd0, 2'b01, 8'h42);
    push_ev(186, 8'he2);
    push_ev(187, 8'hc2);
    push_ev(206, 8'h40);
    push_smp(210, 64'd4, 2'b01, 8'h40);
    push_smp(211, 64'd5, 2'b00, 8'h40);
    push_ev(214, 8'h00);
    wait_cyc(160);
    btn_n[1] = 1'b0;
    wait_cyc(200);
    btn_n[1] = 1'b1;

    // 6: async reset while button 0 is in PRESS, pad held low through release
    push_ev(246, 8'h01);
    push_ev(251, 8'h40);
    push_smp(252, 64'd0, 2'b00, 8'h40);
    push_smp(257, 64'd4, 2'b01, 8'h40);
    push_ev(259, 8'h41);
    push_smp(260, 64'd7, 2'b00, 8'h41);
    push_ev(261, 8'h01);
    push_ev(279, 8'h11);
    push_ev(280, 8'h01);
    push_ev(296, 8'h00);
    wait_cyc(240);
    btn_n[0] = 1'b0;
    wait_cyc(250);
    rst = 1'b1;
    wait_cyc(253);
    rst = 1'b0;
    wait_cyc(290);
    btn_n[0] = 1'b1;

    wait_cyc(320);
    while (ev_q.size() != 0) begin
      ev_t e;
      e = ev_q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL missing_event got none, required cyc=%0d obs=%h", e.cyc, e.obs);
    end
    while (smp_q.size() != 0) begin
      smp_t s;
      s = smp_q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL missing_sample got none, required cyc=%0d", s.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
